loopback_checker: RTL and testbench

LOOPBACK_CHECKER -- requirements
Module: loopback_checker

---
 rtl/loopback_checker_pkg.sv | 18 +
 rtl/loopback_checker_ctr.sv | 23 ++
 rtl/loopback_checker.sv | 153 +++++++++++++++
 tb/tb_loopback_checker.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loopback_checker_pkg.sv
// Shared types and helpers for the loopback sequence checker.
// Holds the checker state enumeration and the 8-bit rotate-right helper.
package loopback_checker_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int BYTE_W = 8;

    function automatic logic [7:0] rotr8(input logic [7:0] x, input logic [2:0] r);
        logic [15:0] t;
        t = {x, x} >> r;
        return t[7:0];
    endfunction

endpackage

// File: rtl/loopback_checker_ctr.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; the count sticks at all-ones.
module loopback_checker_ctr #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/loopback_checker.sv
// Incrementing-counter loopback checker with bit-rotation hunt.
// Finds the word alignment, locks, then counts checked and errored words.
module loopback_checker
    import loopback_checker_pkg::*;
#(
    parameter int LOCK_COUNT = 16,
    parameter int LOSS_COUNT = 4,
    parameter int ERR_W      = 16,
    parameter int WORD_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    input  logic [7:0]        din,
    input  logic              clear,
    output logic              locked,
    output logic [2:0]        rot_sel,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [WORD_W-1:0] word_cnt
);

    localparam logic [7:0] LOCK_N = 8'(LOCK_COUNT);
    localparam logic [7:0] LOSS_N = 8'(LOSS_COUNT);

    state_t     state_q, state_d;
    logic [2:0] rot_q, rot_d;
    logic [7:0] prev_q, prev_d;
    logic       prev_vld_q, prev_vld_d;
    logic [7:0] match_q, match_d;
    logic [7:0] miss_q, miss_d;
    logic [7:0] exp_q, exp_d;
    logic       pulse_q, pulse_d;
    logic       err_inc, word_inc;

    logic [7:0] aligned_din;
    logic [7:0] aligned_prev;
    logic [7:0] prev_inc;
    logic [7:0] match_inc;
    logic [7:0] miss_inc;
    logic       seq_hit;
    logic       lock_hit;

    // Both words use the current candidate so a rotation change is judged fairly
    assign aligned_din  = rotr8(din, rot_q);
    assign aligned_prev = rotr8(prev_q, rot_q);
    assign prev_inc     = aligned_prev + 8'd1;
    assign match_inc    = match_q + 8'd1;
    assign miss_inc     = miss_q + 8'd1;
    assign seq_hit      = (aligned_din == prev_inc);
    assign lock_hit     = (aligned_din == exp_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HUNT;
            rot_q      <= 3'd0;
            prev_q     <= 8'd0;
            prev_vld_q <= 1'b0;
            match_q    <= 8'd0;
            miss_q     <= 8'd0;
            exp_q      <= 8'd0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rot_q      <= rot_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            match_q    <= match_d;
            miss_q     <= miss_d;
            exp_q      <= exp_d;
            pulse_q    <= pulse_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rot_d      = rot_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        match_d    = match_q;
        miss_d     = miss_q;
        exp_d      = exp_q;
        pulse_d    = 1'b0;
        err_inc    = 1'b0;
        word_inc   = 1'b0;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    prev_d     = din;
                    prev_vld_d = 1'b1;
                    if (prev_vld_q) begin
                        if (seq_hit) begin
                            match_d = match_inc;
                            if (match_inc == LOCK_N) begin
                                state_d = LOCKED;
                                exp_d   = aligned_din + 8'd1;
                                miss_d  = 8'd0;
                            end
                        end else begin
                            match_d = 8'd0;
                            rot_d   = rot_q + 3'd1;
                        end
                    end
                end
                LOCKED: begin
                    // Expected free-runs so one bad word costs one error
                    exp_d    = exp_q + 8'd1;
                    word_inc = 1'b1;
                    if (lock_hit) begin
                        miss_d = 8'd0;
                    end else begin
                        err_inc = 1'b1;
                        pulse_d = 1'b1;
                        miss_d  = miss_inc;
                        if (miss_inc == LOSS_N) begin
                            state_d    = HUNT;
                            match_d    = 8'd0;
                            prev_vld_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    assign locked    = (state_q == LOCKED);
    assign rot_sel   = rot_q;
    assign err_pulse = pulse_q;

    loopback_checker_ctr #(
        .W(ERR_W)
    ) u_err_ctr (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .inc  (err_inc),
        .count(err_cnt)
    );

    loopback_checker_ctr #(
        .W(WORD_W)
    ) u_word_ctr (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .inc  (word_inc),
        .count(word_cnt)
    );

endmodule

// File: tb/tb_loopback_checker.sv
// Self-checking bench for loopback_checker.
// Narrow counters make saturation reachable in a short run.
module tb_loopback_checker;

    localparam int EW = 4;
    localparam int WW = 6;
    localparam int ERR_MAX = (1 << EW) - 1;
    localparam int WORD_MAX = (1 << WW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din_valid = 1'b0;
    logic [7:0]    din = 8'd0;
    logic          clear = 1'b0;
    logic          locked;
    logic [2:0]    rot_sel;
    logic          err_pulse;
    logic [EW-1:0] err_cnt;
    logic [WW-1:0] word_cnt;

    loopback_checker #(
        .LOCK_COUNT(16),
        .LOSS_COUNT(4),
        .ERR_W     (EW),
        .WORD_W    (WW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din_valid(din_valid),
        .din      (din),
        .clear    (clear),
        .locked   (locked),
        .rot_sel  (rot_sel),
        .err_pulse(err_pulse),
        .err_cnt  (err_cnt),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference: words the model has seen, plus derived status
    bit m_lock;
    int m_rot, m_prev, m_run, m_miss, m_exp, m_err, m_words;
    bit m_pulse;

    typedef struct {
        bit v;
        int d;
        bit e_lock;
        int e_rot;
    } vec_t;
    vec_t tbl[5];

    function automatic int rr(int x, int r);
        return ((x >> r) | (x << (8 - r))) & 255;
    endfunction

    function automatic int rl(int x, int r);
        return ((x << r) | (x >> (8 - r))) & 255;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        m_lock = 0; m_rot = 0; m_prev = -1; m_run = 0;
        m_miss = 0; m_exp = 0; m_err = 0; m_words = 0; m_pulse = 0;
    endtask

    task automatic model_step(bit v, int d, bit c);
        int a;
        m_pulse = 0;
        if (v) begin
            a = rr(d, m_rot);
            if (!m_lock) begin
                if (m_prev >= 0) begin
                    if (a == ((rr(m_prev, m_rot) + 1) % 256)) begin
                        m_run++;
                        if (m_run == 16) begin
                            m_lock = 1;
                            m_exp = (a + 1) % 256;
                            m_miss = 0;
                        end
                    end else begin
                        m_run = 0;
                        m_rot = (m_rot + 1) % 8;
                    end
                end
                m_prev = d;
            end else begin
                if (m_words < WORD_MAX) m_words++;
                if (a == m_exp) begin
                    m_miss = 0;
                end else begin
                    if (m_err < ERR_MAX) m_err++;
                    m_pulse = 1;
                    m_miss++;
                    if (m_miss == 4) begin
                        m_lock = 0;
                        m_run = 0;
                        m_prev = -1;
                    end
                end
                m_exp = (m_exp + 1) % 256;
            end
        end
        if (c) begin
            m_err = 0;
            m_words = 0;
        end
    endtask

    task automatic cycle(bit v, int d, bit c);
        din_valid = v;
        din = d[7:0];
        clear = c;
        @(posedge clk);
        #1;
        model_step(v, d, c);
        chk("locked", int'(locked), int'(m_lock));
        chk("rot_sel", int'(rot_sel), m_rot);
        chk("err_pulse", int'(err_pulse), int'(m_pulse));
        chk("err_cnt", int'(err_cnt), m_err);
        chk("word_cnt", int'(word_cnt), m_words);
        din_valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        clear = 1'b0;
        #2;
        model_reset();
        chk("rst_locked", int'(locked), 0);
        chk("rst_rot", int'(rot_sel), 0);
        chk("rst_pulse", int'(err_pulse), 0);
        chk("rst_err", int'(err_cnt), 0);
        chk("rst_word", int'(word_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int n, cnt, pulses, sent, r;
        bit c;

        #3;
        do_reset();

        // Clean stream, rotation 0
        for (int i = 0; i < 17; i++) begin
            cycle(1, i, 0);
            if (i == 15) chk("lock_early", int'(locked), 0);
        end
        chk("lock_at_17", int'(locked), 1);
        chk("lock_rot0", int'(rot_sel), 0);
        for (int i = 17; i < 300; i++) cycle(1, i & 255, 0);
        chk("wrap_no_err", int'(err_cnt), 0);
        chk("word_sat", int'(word_cnt), WORD_MAX);

        // Alternating bad/good words saturate err_cnt without losing lock
        n = 300;
        for (int k = 0; k < 20; k++) begin
            cycle(1, (n + 128) & 255, 0);
            n++;
            cycle(1, n & 255, 0);
            n++;
        end
        chk("err_sat", int'(err_cnt), ERR_MAX);
        chk("err_sat_lock", int'(locked), 1);

        // Single corrupted word
        cycle(1, n & 255, 1);
        n++;
        chk("clear_err", int'(err_cnt), 0);
        chk("clear_word", int'(word_cnt), 0);
        pulses = 0;
        cycle(1, 8'h5A, 0);
        n++;
        pulses += int'(err_pulse);
        for (int k = 0; k < 5; k++) begin
            cycle(1, n & 255, 0);
            n++;
            pulses += int'(err_pulse);
        end
        chk("one_pulse", pulses, 1);
        chk("one_err", int'(err_cnt), 1);
        chk("one_err_lock", int'(locked), 1);

        // Stream jumps by +7
        cycle(1, n & 255, 1);
        n++;
        n += 7;
        for (int k = 0; k < 4; k++) begin
            cycle(1, n & 255, 0);
            n++;
            if (k == 2) chk("jump_still_lock", int'(locked), 1);
        end
        chk("jump_lost", int'(locked), 0);
        chk("jump_err4", int'(err_cnt), 4);
        cnt = 0;
        for (int k = 0; k < 17; k++) begin
            if (!locked) begin
                cycle(1, n & 255, 0);
                n++;
                cnt++;
            end
        end
        chk("relock", int'(locked), 1);
        chk("relock_words", cnt, 17);
        chk("relock_err", int'(err_cnt), 4);

        // Clear on the same cycle as a mismatch
        cycle(1, (n + 100) & 255, 1);
        n++;
        chk("clr_mis_err", int'(err_cnt), 0);
        chk("clr_mis_pulse", int'(err_pulse), 1);
        chk("clr_mis_lock", int'(locked), 1);

        // Reset while locked, then relock from an arbitrary start
        do_reset();
        for (int k = 0; k < 17; k++) cycle(1, (n + k) & 255, 0);
        chk("rst_relock", int'(locked), 1);

        // Table: stream rotated left by 3
        do_reset();
        tbl[0] = '{1, rl(0, 3), 0, 0};
        tbl[1] = '{1, rl(1, 3), 0, 1};
        tbl[2] = '{1, rl(2, 3), 0, 2};
        tbl[3] = '{1, rl(3, 3), 0, 3};
        tbl[4] = '{1, rl(4, 3), 0, 3};
        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].d, 0);
            chk("tbl_rot", int'(rot_sel), tbl[i].e_rot);
            chk("tbl_lock", int'(locked), int'(tbl[i].e_lock));
        end
        cnt = 5;
        for (int i = 5; i < 40; i++) begin
            if (!locked) begin
                cycle(1, rl(i, 3), 0);
                cnt++;
            end
        end
        chk("rot3_lock", int'(locked), 1);
        chk("rot3_words", cnt, 20);
        chk("rot3_sel", int'(rot_sel), 3);
        chk("rot3_err", int'(err_cnt), 0);

        // Gapped valid: lock point counted in valid words
        do_reset();
        n = 0;
        cnt = 0;
        for (int k = 0; k < 200 && !locked; k++) begin
            if ($urandom_range(1, 0) == 1) begin
                cycle(1, n & 255, 0);
                n++;
                cnt++;
            end else begin
                cycle(0, $urandom_range(255, 0), 0);
            end
        end
        chk("gap_lock", int'(locked), 1);
        chk("gap_words", cnt, 17);
        sent = 0;
        for (int k = 0; k < 300 && sent < 40; k++) begin
            if ($urandom_range(1, 0) == 1) begin
                cycle(1, n & 255, 0);
                n++;
                sent++;
            end else begin
                cycle(0, $urandom_range(255, 0), 0);
            end
        end
        chk("gap_wordcnt", int'(word_cnt), sent);

        // Random stream with corruption, jumps, rotations and clears
        do_reset();
        n = $urandom_range(255, 0);
        r = 0;
        for (int k = 0; k < 3000; k++) begin
            if (k % 300 == 0) begin
                r = $urandom_range(7, 0);
                n += $urandom_range(255, 0);
            end
            c = ($urandom_range(49, 0) == 0);
            if ($urandom_range(3, 0) != 0) begin
                if ($urandom_range(29, 0) == 0)
                    cycle(1, $urandom_range(255, 0), c);
                else
                    cycle(1, rl(n & 255, r), c);
                n++;
            end else begin
                cycle(0, $urandom_range(255, 0), c);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
